// File: rtl/mitchell_pkg.sv
// mitchell_pkg
//   Shared constants, width helpers and stage-record types for the Mitchell
//   log-domain divider (and the multiplier that shares its log front end).
//   The stage records are sized from the default operand widths below, so a
//   build with different operand widths changes these defaults as well.
//
//   Contents:
//     max_op(), q_width()  width helpers
//     MAX_OP               widest operand, also the log-fraction width
//     K_BW                 width of a leading-one position
//     E_BW                 signed exponent-difference width
//     s1_t                 log stage record   {k1,k2,x1,x2,za,zb,v}
//     s2_t                 subtract stage record {e,m,za,zb,v}

package mitchell_pkg;

    localparam int A_BW_DEF    = 16;
    localparam int B_BW_DEF    = 16;
    localparam int FRAC_BW_DEF = 8;

    function automatic int max_op(input int a_bw, input int b_bw);
        return (a_bw > b_bw) ? a_bw : b_bw;
    endfunction

    function automatic int q_width(input int a_bw, input int frac_bw);
        return a_bw + frac_bw;
    endfunction

    localparam int MAX_OP = max_op(A_BW_DEF, B_BW_DEF);
    localparam int K_BW   = $clog2(MAX_OP);
    localparam int E_BW   = $clog2(MAX_OP) + 2;
    localparam int Q_BW   = q_width(A_BW_DEF, FRAC_BW_DEF);

    typedef struct packed {
        logic [K_BW-1:0]   k1;
        logic [K_BW-1:0]   k2;
        logic [MAX_OP-1:0] x1;
        logic [MAX_OP-1:0] x2;
        logic              za;
        logic              zb;
        logic              v;
    } s1_t;

    typedef struct packed {
        logic signed [E_BW-1:0] e;
        logic [MAX_OP:0]        m;
        logic                   za;
        logic                   zb;
        logic                   v;
    } s2_t;

endpackage

// File: rtl/mitchell_log.sv
// mitchell_log
//   Approximate base-2 log of one unsigned operand: leading-one detect,
//   priority encode to the integer part k, and normalise the bits below the
//   leading one into a left-aligned OUT_BW-bit fraction x.
//   A zero operand yields k=0, x=0; the caller flags zero separately.
//
//   Ports:
//     val  in   IN_BW   operand
//     k    out  K_BW    position of the leading one
//     x    out  OUT_BW  fraction bits below the leading one, left-aligned

module mitchell_log #(
    parameter int IN_BW  = 16,
    parameter int OUT_BW = 16,
    parameter int K_BW   = 4
) (
    input  logic [IN_BW-1:0]  val,
    output logic [K_BW-1:0]   k,
    output logic [OUT_BW-1:0] x
);

    localparam int SW = K_BW + 1;

    logic [SW-1:0] shamt;

    // Highest set bit wins because later loop iterations overwrite earlier.
    always_comb begin
        k = '0;
        for (int i = 0; i < IN_BW; i++) begin
            if (val[i]) k = K_BW'(i);
        end
    end

    // Shifting by OUT_BW-k pushes the leading one just past the MSB, so the
    // OUT_BW-bit result drops it and keeps only the fraction.
    always_comb begin
        shamt = SW'(OUT_BW) - {1'b0, k};
        x     = OUT_BW'(val) << shamt;
    end

endmodule

// File: rtl/mitchell_div.sv
// mitchell_div
//   Approximate unsigned divider, q ~= a/b, using Mitchell's method:
//   subtract approximate logs, then take the approximate antilog.
//   Three register stages (log, subtract, antilog) sharing one enable, with
//   a valid/ready handshake; one result per cycle when not stalled.
//
//   Optional build macro MITCHELL_DIV_ROUND_EN: the antilog right shift
//   rounds half up instead of truncating; saturation applies afterwards.
//
//   Ports:
//     clk          in   1             clock, rising edge
//     rst_n        in   1             async active-low reset
//     in_valid     in   1             operands valid
//     in_ready     out  1             operands accepted this cycle
//     a            in   A_BW          dividend
//     b            in   B_BW          divisor
//     out_valid    out  1             result valid
//     out_ready    in   1             downstream takes the result
//     q            out  A_BW+FRAC_BW  quotient, FRAC_BW fraction bits
//     div_by_zero  out  1             b was zero (q is all ones)

module mitchell_div
    import mitchell_pkg::*;
#(
    parameter int A_BW    = A_BW_DEF,
    parameter int B_BW    = B_BW_DEF,
    parameter int FRAC_BW = FRAC_BW_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [A_BW-1:0]         a,
    input  logic [B_BW-1:0]         b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [A_BW+FRAC_BW-1:0] q,
    output logic                    div_by_zero
);

    localparam int QW    = A_BW + FRAC_BW;
    localparam int W_EXT = QW + MAX_OP + 2;
    localparam int SH_BW = E_BW + 4;

    logic adv;

    logic [K_BW-1:0]   k1_c;
    logic [K_BW-1:0]   k2_c;
    logic [MAX_OP-1:0] x1_c;
    logic [MAX_OP-1:0] x2_c;

    s1_t s1_q;
    s2_t s2_q;
    s2_t s2_c;

    logic signed [SH_BW-1:0] net;
    logic [SH_BW-1:0]        sh_mag;
    logic [W_EXT-1:0]        ext;
    logic [W_EXT-1:0]        val;
    logic [QW-1:0]           q_c;

    // The whole pipe moves as one; it only holds when a finished result is
    // waiting on the output and downstream is not taking it.
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    mitchell_log #(.IN_BW(A_BW), .OUT_BW(MAX_OP), .K_BW(K_BW)) u_log_a (
        .val (a),
        .k   (k1_c),
        .x   (x1_c)
    );

    mitchell_log #(.IN_BW(B_BW), .OUT_BW(MAX_OP), .K_BW(K_BW)) u_log_b (
        .val (b),
        .k   (k2_c),
        .x   (x2_c)
    );

    // Log stage register: both operand logs plus zero flags and valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
        end else if (adv) begin
            s1_q.k1 <= k1_c;
            s1_q.k2 <= k2_c;
            s1_q.x1 <= x1_c;
            s1_q.x2 <= x2_c;
            s1_q.za <= (a == '0);
            s1_q.zb <= (b == '0);
            s1_q.v  <= in_valid;
        end
    end

    // Log difference. When x1<x2 the fraction borrows from the exponent;
    // the modular fraction difference is then exactly x1-x2+1, so the
    // mantissa is 1.(x1-x2 mod 1) in both cases and only e changes.
    always_comb begin
        s2_c    = '0;
        s2_c.e  = E_BW'(s1_q.k1) - E_BW'(s1_q.k2) - E_BW'(s1_q.x1 < s1_q.x2);
        s2_c.m  = {1'b1, s1_q.x1 - s1_q.x2};
        s2_c.za = s1_q.za;
        s2_c.zb = s1_q.zb;
        s2_c.v  = s1_q.v;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_q <= '0;
        end else if (adv) begin
            s2_q <= s2_c;
        end
    end

    // Antilog: q = (m << (e+FRAC_BW)) >> MAX_OP folded into one signed shift
    // by net. An extra guard bit below the mantissa catches the bit shifted
    // out just under the LSB, which is the rounding increment.
    always_comb begin
        net    = SH_BW'($signed(s2_q.e)) + SH_BW'(FRAC_BW) - SH_BW'(MAX_OP);
        sh_mag = net[SH_BW-1] ? SH_BW'(-net) : SH_BW'(net);
        if (net[SH_BW-1]) begin
            ext = W_EXT'({s2_q.m, 1'b0}) >> sh_mag;
        end else begin
            ext = W_EXT'({s2_q.m, 1'b0}) << sh_mag;
        end
        val = ext >> 1;
`ifdef MITCHELL_DIV_ROUND_EN
        val = val + W_EXT'(ext[0]);
`else
`endif
        if (s2_q.zb) begin
            q_c = '1;
        end else if (s2_q.za) begin
            q_c = '0;
        end else if (|val[W_EXT-1:QW]) begin
            q_c = '1;
        end else begin
            q_c = val[QW-1:0];
        end
    end

    // Output register; div_by_zero is gated by valid so bubbles never flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            q           <= '0;
            div_by_zero <= 1'b0;
        end else if (adv) begin
            out_valid   <= s2_q.v;
            q           <= q_c;
            div_by_zero <= s2_q.v & s2_q.zb;
        end
    end

endmodule

// File: tb/tb_mitchell_div.sv
// tb_mitchell_div
//   Self-checking bench for mitchell_div. Expected quotients come from a
//   fixed-point model of Mitchell division: log2(v) ~= k + frac, difference
//   of logs, split into floor exponent and fraction, then 2^e * (1+frac).
//   Build with MITCHELL_DIV_ROUND_EN to check the rounding variant.

module tb_mitchell_div;

    localparam int A_BW    = 16;
    localparam int B_BW    = 16;
    localparam int FRAC_BW = 8;
    localparam int Q_BW    = A_BW + FRAC_BW;
    localparam int N_RAND  = 10000;

    typedef struct {
        logic [A_BW-1:0] a;
        logic [B_BW-1:0] b;
        logic [Q_BW-1:0] q;
        logic            dz;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [A_BW-1:0] a;
    logic [B_BW-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [Q_BW-1:0] q;
    logic            div_by_zero;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    mitchell_div #(.A_BW(A_BW), .B_BW(B_BW), .FRAC_BW(FRAC_BW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .q           (q),
        .div_by_zero (div_by_zero)
    );

    // Fixed-point log2 with 16 fraction bits: k*2^16 + (v-2^k)*2^(16-k).
    function automatic longint log_fix(input logic [15:0] v);
        int k;
        k = 0;
        for (int i = 0; i < 16; i++) if (v[i]) k = i;
        return (longint'(k) << 16) + ((longint'(v) - (longint'(1) << k)) << (16 - k));
    endfunction

    function automatic exp_t golden(input logic [A_BW-1:0] av, input logic [B_BW-1:0] bv);
        exp_t   r;
        longint l, e, f, num, qv;
        int     p;
        r.a  = av;
        r.b  = bv;
        r.dz = 1'b0;
        if (bv == 0) begin
            r.q  = '1;
            r.dz = 1'b1;
            return r;
        end
        if (av == 0) begin
            r.q = '0;
            return r;
        end
        l   = log_fix(av) - log_fix(bv);
        e   = l >>> 16;
        f   = l & 64'hFFFF;
        num = 65536 + f;
        p   = int'(e) + FRAC_BW - 16;
        if (p >= 0) begin
            qv = num << p;
        end else begin
`ifdef MITCHELL_DIV_ROUND_EN
            qv = (num + (longint'(1) << (-p - 1))) >> (-p);
`else
            qv = num >> (-p);
`endif
        end
        if (qv > longint'(24'hFFFFFF)) qv = longint'(24'hFFFFFF);
        r.q = qv[Q_BW-1:0];
        return r;
    endfunction

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #12;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        total++;
        if (q !== '0) begin bad++; $display("[TB] FAIL reset_q: got %h expected 000000", q); end
        total++;
        if (div_by_zero !== 1'b0) begin bad++; $display("[TB] FAIL reset_dbz: got %b expected 0", div_by_zero); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [15:0] ta[5];
        logic [15:0] tb_v[5];
        logic [23:0] tq[5];
        logic        tz[5];
        ta   = '{16'd100, 16'd10, 16'd255, 16'd0, 16'd5};
        tb_v = '{16'd10, 16'd100, 16'd255, 16'd7, 16'd0};
        tq   = '{24'hA80, 24'd27, 24'd256, 24'd0, 24'hFFFFFF};
        tz   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = ta[i]; b = tb_v[i]; in_valid = 1'b1; out_ready = 1'b1;
            @(posedge clk);
            #1 in_valid = 1'b0;
            @(posedge clk);
            #1;
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL dir%0d_early_valid: got %b expected 0", i, out_valid); end
            @(posedge clk);
            #1;
            total++;
            if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL dir%0d_valid: got %b expected 1", i, out_valid); end
            total++;
            if (q !== tq[i]) begin bad++; $display("[TB] FAIL dir%0d_q: got %h expected %h", i, q, tq[i]); end
            total++;
            if (div_by_zero !== tz[i]) begin bad++; $display("[TB] FAIL dir%0d_dbz: got %b expected %b", i, div_by_zero, tz[i]); end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [15:0]     pa[8];
        logic [15:0]     pb[8];
        int              sent, got, stall_cycles;
        bit              stalled_prev;
        logic [Q_BW-1:0] held_q;
        logic            held_z;
        exp_t            ex;
        sent = 0; got = 0; stall_cycles = 0; stalled_prev = 0;
        held_q = '0; held_z = 1'b0;
        sb.delete();
        for (int i = 0; i < 8; i++) begin
            pa[i] = 16'($urandom_range(1, 65535));
            pb[i] = 16'($urandom_range(1, 4000));
        end
        pb[5] = 16'd0;
        for (int c = 0; c < 40 && (sent < 8 || got < 8); c++) begin
            @(negedge clk);
            out_ready = !(c >= 4 && c <= 6);
            if (sent < 8) begin
                in_valid = 1'b1; a = pa[sent]; b = pb[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) begin
                stall_cycles++;
                total++;
                if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL b2b_in_ready_stall: got %b expected 0", in_ready); end
                if (stalled_prev) begin
                    total++;
                    if (q !== held_q || div_by_zero !== held_z) begin
                        bad++; $display("[TB] FAIL b2b_hold: got %h/%b expected %h/%b", q, div_by_zero, held_q, held_z);
                    end
                end
                held_q = q; held_z = div_by_zero; stalled_prev = 1;
            end else begin
                stalled_prev = 0;
            end
            if (out_valid && out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("[TB] FAIL b2b_extra: got %h expected no result", q);
                end else begin
                    ex = sb.pop_front();
                    if (q !== ex.q || div_by_zero !== ex.dz) begin
                        bad++; $display("[TB] FAIL b2b_q%0d: got %h/%b expected %h/%b", got, q, div_by_zero, ex.q, ex.dz);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(golden(a, b));
                sent++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        total++;
        if (got != 8 || sb.size() != 0) begin bad++; $display("[TB] FAIL b2b_count: got %0d expected 8", got); end
        total++;
        if (stall_cycles != 3) begin bad++; $display("[TB] FAIL b2b_stall_len: got %0d expected 3", stall_cycles); end
    endtask

    task automatic test_reset_in_flight();
        exp_t ex;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 16'(100 + i); b = 16'd0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL rif_pre_valid: got %b expected 1", out_valid); end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rif_async_valid: got %b expected 0", out_valid); end
        total++;
        if (q !== '0 || div_by_zero !== 1'b0) begin bad++; $display("[TB] FAIL rif_async_q: got %h/%b expected 000000/0", q, div_by_zero); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rif_stale%0d: got %b expected 0", c, out_valid); end
        end
        @(negedge clk);
        in_valid = 1'b1; a = 16'd300; b = 16'd7;
        ex = golden(a, b);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b1 || q !== ex.q || div_by_zero !== 1'b0) begin
            bad++; $display("[TB] FAIL rif_first: got %b/%h expected 1/%h", out_valid, q, ex.q);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int          sent, got, cyc;
        exp_t        ex;
        logic [15:0] ma, mb;
        real         exact, err;
        sent = 0; got = 0; cyc = 0;
        sb.delete();
        while ((sent < N_RAND || got < N_RAND) && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (sent < N_RAND && $urandom_range(0, 3) != 0) begin
                ma = 16'hFFFF >> $urandom_range(0, 15);
                mb = 16'hFFFF >> $urandom_range(0, 15);
                a  = ($urandom_range(0, 15) == 0) ? 16'd0 : (16'($urandom) & ma);
                b  = ($urandom_range(0, 15) == 0) ? 16'd0 : (16'($urandom) & mb);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("[TB] FAIL rand_extra: got %h expected no result", q);
                end else begin
                    ex = sb.pop_front();
                    if (q !== ex.q || div_by_zero !== ex.dz) begin
                        bad++;
                        $display("[TB] FAIL rand_q a=%0d b=%0d: got %h/%b expected %h/%b", ex.a, ex.b, q, div_by_zero, ex.q, ex.dz);
                    end
                    if (ex.b != 0 && ex.a >= ex.b) begin
                        exact = real'(ex.a) * 256.0 / real'(ex.b);
                        err   = real'(q) - exact;
                        if (err < 0.0) err = -err;
                        total++;
                        // One LSB of slack covers output quantisation.
                        if (err > 0.125 * exact + 1.0) begin
                            bad++; $display("[TB] FAIL rand_relerr a=%0d b=%0d: got %h expected near %f", ex.a, ex.b, q, exact);
                        end
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(golden(a, b));
                sent++;
            end
        end
        in_valid = 1'b0;
        total++;
        if (sent != N_RAND || got != N_RAND) begin
            bad++; $display("[TB] FAIL rand_timeout: got %0d results expected %0d", got, N_RAND);
        end
    endtask

    initial begin
        $display("[TB] mitchell_div bench start");
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_in_flight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
